// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the SRAM sequencer: command encodings and FSM state constants.
package mem_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_COMP  = 2'b01,
    OP_WBACK = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_COMP  = 3'd2;
  localparam state_t ST_WBACK = 3'd3;
  localparam state_t ST_CLEAR = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/mem_sequencer_if.sv
// Command handshake plus SRAM control bundle; the sequencer is the slave of the command side.
interface mem_sequencer_if #(
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_SRAM_IN  = 2,
  parameter int NUM_SRAM_OUT = 1
);
  localparam int NUM_SRAM = NUM_SRAM_IN + NUM_SRAM_OUT;

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [1:0]                     cmd_op;
  logic [ADDR_WIDTH:0]            cmd_len;
  logic                           abort;
  logic                           busy;
  logic                           done;
  logic                           err;
  logic [NUM_SRAM-1:0]            mem_cs;
  logic [NUM_SRAM-1:0]            mem_re;
  logic [NUM_SRAM-1:0]            mem_we;
  logic [NUM_SRAM-1:0]            mem_clear;
  logic [NUM_SRAM*ADDR_WIDTH-1:0] addr_rd;
  logic [NUM_SRAM*ADDR_WIDTH-1:0] addr_wr;
  logic                           rd_valid;
  logic [ADDR_WIDTH+1:0]          step_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_len, abort,
    input  cmd_ready, busy, done, err, mem_cs, mem_re, mem_we, mem_clear,
           addr_rd, addr_wr, rd_valid, step_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, abort,
    output cmd_ready, busy, done, err, mem_cs, mem_re, mem_we, mem_clear,
           addr_rd, addr_wr, rd_valid, step_cnt
  );
endinterface

// File: rtl/mem_sequencer_valid_delay.sv
// READ_LAT-deep shift register that turns the read-enable window into read-data-valid.
module mem_valid_delay #(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_valid
);
  logic [READ_LAT-1:0] r_pipe;

  // Concatenate-and-truncate keeps the shift legal for READ_LAT == 1 as well.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= READ_LAT'({r_pipe, i_valid});
    end
  end

  assign o_valid = r_pipe[READ_LAT-1];
endmodule

// File: rtl/mem_sequencer.sv
// Command-driven address/enable sequencer for the input and result SRAMs of the dot-product datapath.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_SRAM_IN  = 2,
  parameter int NUM_SRAM_OUT = 1,
  parameter int WB_DELAY     = 2,
  parameter int READ_LAT     = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_sequencer_if.slave  bus
);
  localparam int NUM_SRAM  = NUM_SRAM_IN + NUM_SRAM_OUT;
  localparam int CW        = ADDR_WIDTH + 2;
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] WB_C    = CW'(WB_DELAY);
  localparam logic [CW-1:0] RL_C    = CW'(READ_LAT);

  state_t                         r_state;
  logic [CW-1:0]                  r_step;
  logic [CW-1:0]                  r_len;
  logic                           r_err;
  logic [NUM_SRAM-1:0]            r_mem_cs, r_mem_re, r_mem_we, r_mem_clear;
  logic [NUM_SRAM*ADDR_WIDTH-1:0] r_addr_rd, r_addr_wr;

  state_t                         w_state_next;
  logic [CW-1:0]                  w_step_next;
  logic [CW-1:0]                  w_len_next;
  logic [CW-1:0]                  w_len_in;
  logic [CW-1:0]                  w_len_clamped;
  logic [CW-1:0]                  w_total;
  logic                           w_accept;
  logic                           w_len_big;
  logic                           w_in_win;
  logic                           w_wb_win;
  logic                           w_flush;
  logic                           w_rd_valid;
  logic [ADDR_WIDTH-1:0]          w_s_addr;
  logic [ADDR_WIDTH-1:0]          w_wb_addr;
  logic [NUM_SRAM-1:0]            w_cs_next, w_re_next, w_we_next, w_clr_next;
  logic [NUM_SRAM*ADDR_WIDTH-1:0] w_addr_rd_next, w_addr_wr_next;

  assign w_accept      = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_len_in      = CW'(bus.cmd_len);
  assign w_len_big     = (w_len_in > DEPTH_C);
  assign w_len_clamped = w_len_big ? DEPTH_C : w_len_in;
  assign w_len_next    = w_accept ? w_len_clamped : r_len;
  assign w_flush       = bus.abort && (r_state != ST_IDLE);

  // Phase length in cycles; a zero-length op still spends one empty cycle before DONE.
  always_comb begin
    w_total = CW'(1);
    case (r_state)
      ST_LOAD:  if (r_len != '0) w_total = r_len;
      ST_COMP:  if (r_len != '0) w_total = r_len + WB_C;
      ST_WBACK: if (r_len != '0) w_total = r_len + RL_C;
      default:  ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_step_next  = '0;
    if (w_flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (op_e'(bus.cmd_op))
              OP_LOAD:  w_state_next = ST_LOAD;
              OP_COMP:  w_state_next = ST_COMP;
              OP_WBACK: w_state_next = ST_WBACK;
              default:  w_state_next = ST_CLEAR;
            endcase
          end
        end
        ST_LOAD, ST_COMP, ST_WBACK: begin
          if (r_step == w_total - CW'(1)) begin
            w_state_next = ST_DONE;
          end else begin
            w_step_next = r_step + CW'(1);
          end
        end
        ST_CLEAR: w_state_next = ST_DONE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_in_win  = (w_step_next < w_len_next);
  assign w_wb_win  = (w_step_next >= WB_C);
  assign w_s_addr  = w_step_next[ADDR_WIDTH-1:0];
  assign w_wb_addr = ADDR_WIDTH'(w_step_next - WB_C);

  // Per-SRAM enables are decoded from the next state so every memory output leaves a flop.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRAM; gi++) begin : g_sram
      localparam bit IS_IN = (gi < NUM_SRAM_IN);
      logic                  w_cs, w_re, w_we, w_clr;
      logic [ADDR_WIDTH-1:0] w_ard, w_awr;

      always_comb begin
        w_cs  = 1'b0;
        w_re  = 1'b0;
        w_we  = 1'b0;
        w_clr = 1'b0;
        w_ard = '0;
        w_awr = '0;
        case (w_state_next)
          ST_LOAD: begin
            if (IS_IN && w_in_win) begin
              w_cs  = 1'b1;
              w_we  = 1'b1;
              w_awr = w_s_addr;
            end
          end
          ST_COMP: begin
            if (w_len_next != '0) begin
              w_cs = 1'b1;
              if (IS_IN) begin
                if (w_in_win) begin
                  w_re  = 1'b1;
                  w_ard = w_s_addr;
                end
              end else if (w_wb_win) begin
                w_we  = 1'b1;
                w_awr = w_wb_addr;
              end
            end
          end
          ST_WBACK: begin
            if (!IS_IN && w_in_win) begin
              w_cs  = 1'b1;
              w_re  = 1'b1;
              w_ard = w_s_addr;
            end
          end
          ST_CLEAR: begin
            w_cs  = 1'b1;
            w_clr = 1'b1;
          end
          default: ;
        endcase
      end

      assign w_cs_next[gi]  = w_cs;
      assign w_re_next[gi]  = w_re;
      assign w_we_next[gi]  = w_we;
      assign w_clr_next[gi] = w_clr;
      assign w_addr_rd_next[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_ard;
      assign w_addr_wr_next[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_awr;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_len       <= '0;
      r_err       <= 1'b0;
      r_mem_cs    <= '0;
      r_mem_re    <= '0;
      r_mem_we    <= '0;
      r_mem_clear <= '0;
      r_addr_rd   <= '0;
      r_addr_wr   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_step      <= w_step_next;
      r_len       <= w_len_next;
      r_mem_cs    <= w_cs_next;
      r_mem_re    <= w_re_next;
      r_mem_we    <= w_we_next;
      r_mem_clear <= w_clr_next;
      r_addr_rd   <= w_addr_rd_next;
      r_addr_wr   <= w_addr_wr_next;
      if (w_accept) begin
        r_err <= w_len_big;
      end
    end
  end

  mem_valid_delay #(
    .READ_LAT (READ_LAT)
  ) u_rd_valid (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_valid (|r_mem_re[NUM_SRAM-1:NUM_SRAM_IN]),
    .o_valid (w_rd_valid)
  );

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.err       = r_err;
  assign bus.mem_cs    = r_mem_cs;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_clear = r_mem_clear;
  assign bus.addr_rd   = r_addr_rd;
  assign bus.addr_wr   = r_addr_wr;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.step_cnt  = r_step;
endmodule
